// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event decoder.
//   key_state_e     : FSM state encoding (idle, first press, release gap, second press, long hold)
//   EVT_*           : event_code values driven while event_valid is high
//   max_u()         : larger of two unsigned values, used to size the shared timer
package key_evt_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPress1 = 3'd1,
    StGap    = 3'd2,
    StPress2 = 3'd3,
    StHold   = 3'd4
  } key_state_e;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SINGLE = 2'b01;
  localparam logic [1:0] EVT_DOUBLE = 2'b10;
  localparam logic [1:0] EVT_LONG   = 2'b11;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_evt_timer.sv
// Saturating up-counter shared by all timed FSM states.
//   clk_100M : clock, rising edge
//   rst      : asynchronous active-high reset, count -> 0
//   clear    : synchronous clear to 0 (has priority over enable)
//   enable   : advance by one per cycle, holding at all-ones
//   count    : current count
module key_evt_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies a debounced key into single, double and long press events.
//   clk_100M    : clock, rising edge
//   rst         : asynchronous active-high reset
//   key_in      : debounced key level, 1 = pressed
//   event_valid : one-cycle strobe for a classified event
//   event_code  : 01 single, 10 double, 11 long; 00 when event_valid is low
//   busy        : high while a press sequence is being tracked
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 100_000_000,
  parameter int unsigned GAP_CYCLES  = 30_000_000
) (
  input  logic       clk_100M,
  input  logic       rst,
  input  logic       key_in,
  output logic       event_valid,
  output logic [1:0] event_code,
  output logic       busy
);

  localparam int unsigned TimerW = $clog2(max_u(LONG_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [TimerW-1:0] LongLast = TimerW'(LONG_CYCLES - 1);
  localparam logic [TimerW-1:0] GapLast  = TimerW'(GAP_CYCLES - 1);

  key_state_e        r_state;
  key_state_e        w_state_next;
  logic              r_key_d;
  logic              r_event_valid;
  logic [1:0]        r_event_code;
  logic              w_rise;
  logic              w_fall;
  logic              w_emit;
  logic [1:0]        w_code;
  logic              w_timer_clear;
  logic              w_timer_en;
  logic [TimerW-1:0] w_timer;

  // key_d resets high so a key held across reset must be released before it counts.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_key_d <= 1'b1;
    end else begin
      r_key_d <= key_in;
    end
  end

  assign w_rise = key_in & ~r_key_d;
  assign w_fall = ~key_in & r_key_d;

  // Timer restarts from zero on entry to every state.
  assign w_timer_clear = (w_state_next != r_state);
  assign w_timer_en    = (r_state != StIdle);

  key_evt_timer #(
    .WIDTH (TimerW)
  ) u_timer (
    .clk_100M (clk_100M),
    .rst      (rst),
    .clear    (w_timer_clear),
    .enable   (w_timer_en),
    .count    (w_timer)
  );

  // Key edges are tested before terminal counts so an edge on the last cycle wins.
  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_code       = EVT_NONE;
    unique case (r_state)
      StIdle: begin
        if (w_rise) w_state_next = StPress1;
      end
      StPress1: begin
        if (w_fall) begin
          w_state_next = StGap;
        end else if ((w_timer == LongLast) && key_in) begin
          w_state_next = StHold;
          w_emit       = 1'b1;
          w_code       = EVT_LONG;
        end
      end
      StGap: begin
        if (w_rise) begin
          w_state_next = StPress2;
        end else if (w_timer == GapLast) begin
          w_state_next = StIdle;
          w_emit       = 1'b1;
          w_code       = EVT_SINGLE;
        end
      end
      StPress2: begin
        if (w_fall) begin
          w_state_next = StIdle;
          w_emit       = 1'b1;
          w_code       = EVT_DOUBLE;
        end else if ((w_timer == LongLast) && key_in) begin
          // A second press held long is reported as long; the pending double is dropped.
          w_state_next = StHold;
          w_emit       = 1'b1;
          w_code       = EVT_LONG;
        end
      end
      StHold: begin
        if (w_fall) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_event_valid <= 1'b0;
      r_event_code  <= EVT_NONE;
    end else begin
      r_state       <= w_state_next;
      r_event_valid <= w_emit;
      r_event_code  <= w_code;
    end
  end

  assign event_valid = r_event_valid;
  assign event_code  = r_event_code;
  assign busy        = (r_state != StIdle);

endmodule
